// File: rtl/scene_pkg.sv
// Shared scene constants: cell types, map geometry, address width.
// Used by the map controller, its level ROM and the removal interface.
package scene_pkg;

  localparam int MAP_W   = 20;
  localparam int MAP_H   = 15;
  localparam int N_CELLS = MAP_W * MAP_H;
  localparam int ADDR_W  = 9;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t CELLS = addr_t'(N_CELLS);

  typedef enum logic [1:0] {
    BG     = 2'd0,
    BLOCK  = 2'd1,
    CACTUS = 2'd2,
    COIN   = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_READY
  } state_t;

  function automatic logic in_map(input addr_t a);
    return a < CELLS;
  endfunction

endpackage

// File: rtl/scene_map_controller_if.sv
// Coin-removal request/acknowledge bundle between game logic
// and the scene map controller.
interface scene_map_controller_if;
  import scene_pkg::*;

  logic  remove_req;
  addr_t remove_addr;
  logic  remove_ack;

  modport master (
    output remove_req,
    output remove_addr,
    input  remove_ack
  );

  modport slave (
    input  remove_req,
    input  remove_addr,
    output remove_ack
  );

endinterface

// File: rtl/scene_level_rom.sv
// Level ROM: four procedurally laid out 20x15 levels, one cycle
// latency. Addresses past the map read as background.
module scene_level_rom
  import scene_pkg::*;
(
  input  logic       clk,
  input  logic [1:0] level,
  input  addr_t      addr,
  output logic [1:0] data
);

  cell_t data_q;
  cell_t data_d;

  // Floor on row 14, platform studs on odd columns of row 1,
  // coins on row 2 and cacti on row 13, shifted per level.
  function automatic cell_t cell_at(
    input logic [1:0] lv,
    input addr_t      a
  );
    addr_t y;
    addr_t x;
    addr_t lx;
    cell_t c;
    y  = a / addr_t'(MAP_W);
    x  = a - y * addr_t'(MAP_W);
    lx = x + addr_t'(lv);
    c  = BG;
    unique case (1'b1)
      !in_map(a):
        c = BG;
      (y == 9'd14):
        c = BLOCK;
      (y == 9'd1) && x[0]:
        c = BLOCK;
      (y == 9'd2) && (lx % 9'd3 == 9'd1):
        c = COIN;
      (y == 9'd13) && (lx % 9'd5 == 9'd0):
        c = CACTUS;
      default:
        c = BG;
    endcase
    return c;
  endfunction

  // Table lookup for the requested level and cell.
  always_comb begin
    data_d = cell_at(level, addr);
  end

  // Registered output gives the one-cycle ROM latency.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/scene_map_controller.sv
// Scene map: loads a level from ROM, serves collision/VGA reads,
// clears coins. Coin counter built only with SCENE_COIN_COUNT_EN.
module scene_map_controller
  import scene_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_req,
  input  logic [1:0]             level_sel,
  output logic                   ready,
  input  addr_t                  col_addr,
  output logic [1:0]             col_type,
  input  addr_t                  vga_addr,
  output logic [1:0]             vga_type,
  scene_map_controller_if.slave  rm,
  output logic [8:0]             coins_left,
  output logic                   coins_zero
);

  state_t     state_q;
  state_t     state_d;
  addr_t      rom_addr_q;
  addr_t      rom_addr_d;
  logic [1:0] level_q;
  logic [1:0] level_d;
  logic       ack_q;
  logic       ack_d;
  cell_t      vga_q;
  cell_t      vga_d;

  logic [1:0] rom_data;

  cell_t      map_q [N_CELLS];
  logic       map_we;
  addr_t      map_wa;
  cell_t      map_wd;
  cell_t      rm_cell;

  scene_level_rom u_rom (
    .clk   (clk),
    .level (level_q),
    .addr  (rom_addr_q),
    .data  (rom_data)
  );

  assign ready = (state_q == S_READY);

  assign col_type =
    (ready && in_map(col_addr)) ? map_q[col_addr] : BG;

  assign rm_cell =
    in_map(rm.remove_addr) ? map_q[rm.remove_addr] : BG;

  // The counter runs to 301: ROM data for cell n lands when it
  // reads n+1 and is written then, so the last write is at 300
  // and READY follows one edge later.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    level_d    = level_q;
    ack_d      = 1'b0;
    map_we     = 1'b0;
    map_wa     = rom_addr_q - 9'd1;
    map_wd     = cell_t'(rom_data);
    vga_d      =
      (ready && in_map(vga_addr)) ? map_q[vga_addr] : BG;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_LOAD: begin
        rom_addr_d = rom_addr_q + 9'd1;
        map_we     = (rom_addr_q != '0) &&
                     (rom_addr_q <= CELLS);
        if (rom_addr_q == CELLS + 9'd1) begin
          state_d    = S_READY;
          rom_addr_d = '0;
        end
      end
      S_READY: begin
        if (rm.remove_req) begin
          ack_d  = 1'b1;
          map_wa = rm.remove_addr;
          map_wd = BG;
          map_we = (rm_cell == COIN);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (load_req) begin
      state_d    = S_LOAD;
      rom_addr_d = '0;
      level_d    = level_sel;
      ack_d      = 1'b0;
      map_we     = 1'b0;
    end
  end

  // Control state, counters and registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      level_q    <= '0;
      ack_q      <= 1'b0;
      vga_q      <= BG;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      level_q    <= level_d;
      ack_q      <= ack_d;
      vga_q      <= vga_d;
    end
  end

  // Map RAM write port, shared by load and coin removal.
  always_ff @(posedge clk) begin
    if (!rst && map_we) begin
      map_q[map_wa] <= map_wd;
    end
  end

  assign vga_type      = vga_q;
  assign rm.remove_ack = ack_q;

`ifdef SCENE_COIN_COUNT_EN
  logic [8:0] coins_q;
  logic [8:0] coins_d;
  logic       zero_q;
  logic       zero_d;

  // Count coins as they are loaded, drop one per real removal.
  // The zero flag trails the count by a clock and falls with
  // ready on a reload.
  always_comb begin
    coins_d = coins_q;
    if (load_req) begin
      coins_d = '0;
    end else if (map_we && (state_q == S_LOAD) &&
                 (map_wd == COIN)) begin
      coins_d = coins_q + 9'd1;
    end else if (map_we && (state_q == S_READY)) begin
      coins_d = coins_q - 9'd1;
    end
    zero_d = (state_q == S_READY) &&
             (state_d == S_READY) &&
             (coins_q == '0);
  end

  // Coin counter and zero flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      coins_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      coins_q <= coins_d;
      zero_q  <= zero_d;
    end
  end

  assign coins_left = coins_q;
  assign coins_zero = zero_q;
`else
  assign coins_left = '0;
  assign coins_zero = 1'b0;
`endif

endmodule
